// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared binary32 field widths, saturation constants and stage types
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int INT_W    = 32;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_MAX      = '1;
    localparam logic [INT_W-1:0] INT_MAX      = 32'h7FFF_FFFF;
    localparam logic [INT_W-1:0] INT_MIN      = 32'h8000_0000;
    // -2^31 is the only value with e = 158 that still fits in an int32
    localparam logic [31:0]      F32_NEG_2P31 = 32'hCF00_0000;

    // S1 payload: sign, rounded magnitude and the special-case flags
    typedef struct packed {
        logic             sign;
        logic             sat;
        logic             nan;
        logic [INT_W-1:0] mag;
    } s1_t;

    // Final result from an S1 payload: saturation select or conditional negation
    function automatic logic [INT_W-1:0] ftoi_finish(input s1_t s);
        logic [INT_W-1:0] r;
        if (s.sat) begin
            r = (s.nan || !s.sign) ? INT_MAX : INT_MIN;
        end else if (s.sign) begin
            r = ~s.mag + 1'b1;
        end else begin
            r = s.mag;
        end
        return r;
    endfunction

endpackage

// File: rtl/ftoi_core.sv
// rtl/ftoi_core.sv - combinational binary32 decode, align and round-half-away
module ftoi_core
    import fpu_pkg::*;
(
    input  logic [31:0] x,
    output s1_t         s1
);

    // e at or above E_ALIGN has no fraction bits left; below it we shift right
    localparam logic [EXP_W-1:0] E_HALF  = EXP_W'(EXP_BIAS - 1);
    localparam logic [EXP_W-1:0] E_ALIGN = EXP_W'(EXP_BIAS + MAN_W);
    localparam logic [EXP_W-1:0] E_SAT   = EXP_W'(EXP_BIAS + INT_W - 1);

    logic             sgn;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [MAN_W:0]   sig;
    logic [EXP_W-1:0] down_amt;
    logic [EXP_W-1:0] up_amt;
    logic [MAN_W+1:0] t_down;
    logic [INT_W-1:0] mag_down;
    logic [INT_W-1:0] mag_up;

    assign sgn      = x[31];
    assign e        = x[30:23];
    assign m        = x[22:0];
    assign sig      = {1'b1, m};
    assign down_amt = E_ALIGN - e;
    assign up_amt   = e - E_ALIGN;

    // t_down keeps one extra LSB so bit 0 is the first discarded bit (the round bit)
    assign t_down   = {sig, 1'b0} >> down_amt;
    assign mag_down = {8'd0, t_down[MAN_W+1:1]} + {31'd0, t_down[0]};
    assign mag_up   = {8'd0, sig} << up_amt;

    // Classify the operand and pick the rounded magnitude or a saturation flag
    always_comb begin
        s1      = '0;
        s1.sign = sgn;
        if (e == EXP_MAX && m != '0) begin
            s1.sat = 1'b1;
            s1.nan = 1'b1;
        end else if (x == F32_NEG_2P31) begin
            s1.mag = INT_MIN;
        end else if (e >= E_SAT) begin
            s1.sat = 1'b1;
        end else if (e >= E_ALIGN) begin
            s1.mag = mag_up;
        end else if (e > E_HALF) begin
            s1.mag = mag_down;
        end else if (e == E_HALF) begin
            s1.mag = 32'd1;
        end else begin
            s1.mag = '0;
        end
    end

endmodule

// File: rtl/ftoi.sv
// rtl/ftoi.sv - two-stage binary32 to int32 converter with valid/ready handshake
module ftoi
    import fpu_pkg::*;
(
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] y,
    output logic             ovf
);

    s1_t              core_s1;
    s1_t              s1_q;
    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [INT_W-1:0] y_q;
    logic             ovf_q;

    ftoi_core u_core (
        .x  (x),
        .s1 (core_s1)
    );

    // A stage moves when it is empty or the stage below it moves this cycle
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign y         = y_q;
    assign ovf       = ovf_q;

    // S1: capture the decoded, rounded operand
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= core_s1;
            end
        end
    end

    // S2: final signed result; bubbles load zero so y/ovf read 0 when idle
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            y_q      <= s1_valid ? ftoi_finish(s1_q) : '0;
            ovf_q    <= s1_valid && s1_q.sat;
        end
    end

endmodule

// File: tb/tb_ftoi.sv
// tb/tb_ftoi.sv - randomized scoreboard bench for ftoi
module tb_ftoi;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;

    always #5 sys_clk = ~sys_clk;

    ftoi dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [32:0] exp_q[$];
    bit          hold_pending = 0;
    logic [31:0] hold_y;
    logic        hold_ovf;

    logic [31:0] dir_x [14] = '{32'h3FC00000, 32'hBFC00000, 32'h3F000000, 32'h3EFFFFFF,
                                32'h80000000, 32'h4B7FFFFF, 32'h4F000000, 32'hCF000000,
                                32'hCF000001, 32'h7FC00000, 32'hFF800000, 32'hBF000000,
                                32'h3FA00000, 32'h40200000};
    logic [31:0] dir_y [14] = '{32'h00000002, 32'hFFFFFFFE, 32'h00000001, 32'h00000000,
                                32'h00000000, 32'h00FFFFFF, 32'h7FFFFFFF, 32'h80000000,
                                32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                                32'h00000001, 32'h00000003};
    logic        dir_o [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: round |x| to nearest (ties away) in real arithmetic, then saturate
    function automatic logic [32:0] model(input logic [31:0] xv);
        logic   s;
        int     e;
        int     m;
        real    mag;
        real    r;
        longint li;
        s = xv[31];
        e = int'(xv[30:23]);
        m = int'(xv[22:0]);
        if (e == 255 && m != 0) return {1'b1, 32'h7FFFFFFF};
        if (e == 255) return s ? {1'b1, 32'h80000000} : {1'b1, 32'h7FFFFFFF};
        if (e == 0) mag = real'(m) * (2.0 ** (-149));
        else        mag = (8388608.0 + real'(m)) * (2.0 ** (e - 150));
        r = $floor(mag + 0.5);
        if (!s) begin
            if (r >= 2147483648.0) return {1'b1, 32'h7FFFFFFF};
            li = longint'(r);
            return {1'b0, li[31:0]};
        end
        if (r > 2147483648.0) return {1'b1, 32'h80000000};
        li = -longint'(r);
        return {1'b0, li[31:0]};
    endfunction

    task automatic monitor();
        logic [32:0] e;
        if (hold_pending) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_y", y, hold_y);
            check("hold_ovf", 32'(ovf), 32'(hold_ovf));
        end
        if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else if (out_valid) begin
            e = exp_q[0];
            check("sb_y", y, e[31:0]);
            check("sb_ovf", 32'(ovf), 32'(e[32]));
            if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_valid) begin
            check("idle_y", y, 32'd0);
            check("idle_ovf", 32'(ovf), 32'd0);
        end
        hold_pending = out_valid && !out_ready;
        hold_y       = y;
        hold_ovf     = ovf;
        if (in_valid && in_ready) exp_q.push_back(model(x));
    endtask

    task automatic cycle(input logic v, input logic [31:0] xv, input logic ordy);
        @(posedge sys_clk);
        #1;
        in_valid  = v;
        x         = xv;
        out_ready = ordy;
        @(negedge sys_clk);
        monitor();
    endtask

    function automatic logic [31:0] rand_x();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2, 3:    e = 8'($urandom_range(0, 255));
            default: e = 8'($urandom_range(120, 160));
        endcase
        m = 23'($urandom);
        if ($urandom_range(0, 3) == 0) m = m & 23'h7F0000;
        if ($urandom_range(0, 7) == 0) m = '0;
        return {1'($urandom), e, m};
    endfunction

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", y, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'h3F800000, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        exp_q.delete();
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        cycle(1'b0, 32'h0, 1'b1);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed values with latency check
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, dir_x[i], 1'b1);
            cycle(1'b0, 32'h0, 1'b1);
            check("lat_early", 32'(out_valid), 32'd0);
            cycle(1'b0, 32'h0, 1'b1);
            check("lat_valid", 32'(out_valid), 32'd1);
            check("dir_y", y, dir_y[i]);
            check("dir_ovf", 32'(ovf), 32'(dir_o[i]));
        end

        // Back-to-back burst: one result per cycle
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, rand_x(), 1'b1);
            if (i >= 2) check("burst_valid", 32'(out_valid), 32'd1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

        // Backpressure: 1.0, 2.0, 3.0 with the consumer stalled
        cycle(1'b1, 32'h3F800000, 1'b0);
        cycle(1'b1, 32'h40000000, 1'b0);
        cycle(1'b1, 32'h40400000, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_y_held", y, 32'd1);
        cycle(1'b1, 32'h40400000, 1'b0);
        cycle(1'b1, 32'h40400000, 1'b0);
        check("bp_y_held", y, 32'd1);
        cycle(1'b1, 32'h40400000, 1'b1);
        check("bp_out0_valid", 32'(out_valid), 32'd1);
        check("bp_out0", y, 32'd1);
        cycle(1'b0, 32'h0, 1'b1);
        check("bp_out1_valid", 32'(out_valid), 32'd1);
        check("bp_out1", y, 32'd2);
        cycle(1'b0, 32'h0, 1'b1);
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2", y, 32'd3);
        cycle(1'b0, 32'h0, 1'b1);

        // Reset with two operands in flight
        cycle(1'b1, 32'h40A00000, 1'b0);
        cycle(1'b1, 32'hC1200000, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        check("mid_full", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_y", y, 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        hold_pending = 0;
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check("rst_no_ghost", 32'(out_valid), 32'd0);
        end

        // Random regression against the reference model
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), rand_x(), 1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b1);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
